perf_sampler: RTL and testbench

- Sits directly downstream of the performance counter block; consumes its free-running cycle, instret and per-event 32-bit counts.
- Every programmable interval it computes deltas of cycle count, instret count and one selected event count since the previous sample.
- Pushes each sample as a 96-bit record into a small FIFO, drained by a valid/ready stream to the trace/debug path.
- Loses no counts on backpressure: a dropped sample folds its interval into the next accepted sample.

---
 rtl/perf_pkg.sv | 15 +
 rtl/perf_sampler_if.sv | 11 +
 rtl/perf_sample_fifo.sv | 71 +++++++
 rtl/perf_sampler.sv | 137 +++++++++++++
 tb/tb_perf_sampler.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared sample record layout and sampler state encoding
package perf_pkg;

    localparam int CNT_W    = 32;
    localparam int SAMPLE_W = 96;
    localparam int CYC_LSB  = 0;
    localparam int INS_LSB  = 32;
    localparam int EVT_LSB  = 64;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/perf_sampler_if.sv
// rtl/perf_sampler_if.sv - sample stream towards the trace/debug path
interface perf_sampler_if import perf_pkg::*; ();

    logic                smp_valid;
    logic                smp_ready;
    logic [SAMPLE_W-1:0] smp_data;

    modport master (output smp_valid, output smp_data, input smp_ready);
    modport slave  (input smp_valid, input smp_data, output smp_ready);

endinterface

// File: rtl/perf_sample_fifo.sv
// rtl/perf_sample_fifo.sv - registered synchronous FIFO holding sample records
module perf_sample_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    // A pop frees a slot for a same-cycle push even when full; empty never pops.
    always_comb begin
        do_pop   = pop && (level_q != '0);
        do_push  = push && ((level_q != LVL_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage, pointers and occupancy registers; reset flushes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;

endmodule

// File: rtl/perf_sampler.sv
// rtl/perf_sampler.sv - periodic delta sampler of cycle/instret/event counters
module perf_sampler import perf_pkg::*; #(
    parameter int NUM_EVENTS = 32,
    parameter int SEL_W      = 5,
    parameter int PERIOD_W   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_enable,
    input  logic [PERIOD_W-1:0]           cfg_period,
    input  logic [SEL_W-1:0]              cfg_evt_sel,
    input  logic [CNT_W-1:0]              cycle_count,
    input  logic [CNT_W-1:0]              instret_count,
    input  logic [CNT_W*NUM_EVENTS-1:0]   event_counts_flat,
    perf_sampler_if.master                smp,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          running
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]    snap_cyc_q, snap_cyc_d;
    logic [CNT_W-1:0]    snap_ins_q, snap_ins_d;
    logic [CNT_W-1:0]    snap_evt_q, snap_evt_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic [SEL_W-1:0]    evt_sel_src;
    logic [CNT_W-1:0]    evt_cur;
    logic                tick, fifo_pop, fifo_full, fifo_empty, push_ok, drop;
    logic [SAMPLE_W-1:0] record;

    // Baseline uses the live select in IDLE; samples use the latched one in RUN.
    always_comb begin
        evt_sel_src = (state_q == S_IDLE) ? cfg_evt_sel : sel_q;
        evt_cur     = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (evt_sel_src == SEL_W'(i)) begin
                evt_cur = event_counts_flat[CNT_W*i +: CNT_W];
            end
        end
    end

    assign tick     = (state_q == S_RUN) && (period_cnt_q == '0);
    assign fifo_pop = smp.smp_valid && smp.smp_ready;
    assign push_ok  = tick && (!fifo_full || fifo_pop);
    assign drop     = tick && fifo_full && !fifo_pop;
    assign record   = {evt_cur - snap_evt_q, instret_count - snap_ins_q, cycle_count - snap_cyc_q};

    // Next state: start/stop, interval countdown, snapshot advance, drop tally.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        period_d     = period_q;
        period_cnt_d = period_cnt_q;
        snap_cyc_d   = snap_cyc_q;
        snap_ins_d   = snap_ins_q;
        snap_evt_d   = snap_evt_q;
        drop_d       = drop_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_enable) begin
                    state_d      = S_RUN;
                    sel_d        = cfg_evt_sel;
                    period_d     = cfg_period;
                    period_cnt_d = cfg_period;
                    snap_cyc_d   = cycle_count;
                    snap_ins_d   = instret_count;
                    snap_evt_d   = evt_cur;
                end
            end
            S_RUN: begin
                period_cnt_d = tick ? period_q : period_cnt_q - PERIOD_W'(1);
                // A dropped sample leaves the snapshots alone so its interval merges forward.
                if (push_ok) begin
                    snap_cyc_d = cycle_count;
                    snap_ins_d = instret_count;
                    snap_evt_d = evt_cur;
                end
                if (drop && (drop_q != '1)) begin
                    drop_d = drop_q + DROP_W'(1);
                end
                if (!cfg_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and sampling registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            period_q     <= '0;
            period_cnt_q <= '0;
            snap_cyc_q   <= '0;
            snap_ins_q   <= '0;
            snap_evt_q   <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            period_q     <= period_d;
            period_cnt_q <= period_cnt_d;
            snap_cyc_q   <= snap_cyc_d;
            snap_ins_q   <= snap_ins_d;
            snap_evt_q   <= snap_evt_d;
            drop_q       <= drop_d;
        end
    end

    perf_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tick),
        .push_data (record),
        .pop       (fifo_pop),
        .pop_data  (smp.smp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign smp.smp_valid = !fifo_empty;
    assign drop_count    = drop_q;
    assign running       = (state_q == S_RUN);

endmodule

// File: tb/tb_perf_sampler.sv
// tb/tb_perf_sampler.sv - randomized self-checking bench for perf_sampler
module tb_perf_sampler;
    import perf_pkg::*;

    localparam int NE = 16;
    localparam int SW = 5;
    localparam int PW = 16;
    localparam int FD = 8;
    localparam int DW = 16;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_enable;
    logic [PW-1:0]     cfg_period;
    logic [SW-1:0]     cfg_evt_sel;
    logic [31:0]       cycle_count, instret_count;
    logic [31:0]       evt [NE];
    logic [32*NE-1:0]  flat;
    logic [LW-1:0]     fifo_level;
    logic [DW-1:0]     drop_count;
    logic              running;

    perf_sampler_if smp();

    always #5 clk = ~clk;

    always_comb begin
        flat = '0;
        for (int i = 0; i < NE; i++) flat[32*i +: 32] = evt[i];
    end

    perf_sampler #(
        .NUM_EVENTS(NE), .SEL_W(SW), .PERIOD_W(PW), .FIFO_DEPTH(FD), .DROP_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
        .cfg_evt_sel(cfg_evt_sel), .cycle_count(cycle_count), .instret_count(instret_count),
        .event_counts_flat(flat), .smp(smp), .fifo_level(fifo_level),
        .drop_count(drop_count), .running(running)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: interval sampler described by elapsed-cycle arithmetic and a record queue.
    bit          m_run;
    int          m_k, m_period, m_sel, m_drops;
    logic [31:0] m_bc, m_bi, m_be;
    logic [95:0] m_q [$];
    int          n, mode;

    function automatic logic [31:0] sel_evt(int s);
        if (s < NE) return evt[s];
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_k = 0; m_period = 0; m_sel = 0; m_drops = 0;
        m_bc = 0; m_bi = 0; m_be = 0;
        m_q.delete();
    endtask

    task automatic model_update();
        bit pop, push;
        logic [95:0] rec;
        pop  = (m_q.size() != 0) && smp.smp_ready;
        push = 0;
        rec  = '0;
        if (!m_run) begin
            if (cfg_enable) begin
                m_run = 1; m_k = 0; m_period = int'(cfg_period); m_sel = int'(cfg_evt_sel);
                m_bc = cycle_count; m_bi = instret_count; m_be = sel_evt(m_sel);
            end
        end else begin
            if ((m_k % (m_period + 1)) == m_period) begin
                rec = {sel_evt(m_sel) - m_be, instret_count - m_bi, cycle_count - m_bc};
                if (m_q.size() < FD || pop) begin
                    push = 1;
                    m_bc = cycle_count; m_bi = instret_count; m_be = sel_evt(m_sel);
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end
            m_k++;
            if (!cfg_enable) m_run = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(rec);
    endtask

    task automatic advance();
        n++;
        cycle_count = cycle_count + 32'd1;
        if (mode == 0) begin
            if (n % 2 == 0) instret_count = instret_count + 32'd1;
            if (n % 5 == 0) evt[3] = evt[3] + 32'd1;
            for (int i = 0; i < NE; i++) if (i != 3) evt[i] = evt[i] + 32'($urandom_range(0, 3));
        end else begin
            instret_count = instret_count + 32'($urandom_range(0, 3));
            for (int i = 0; i < NE; i++) evt[i] = evt[i] + 32'($urandom_range(0, 5));
        end
    endtask

    task automatic cycle();
        advance();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        cfg_enable = 0;
        smp.smp_ready = 1;
        for (int i = 0; i < 24 && (m_q.size() != 0 || m_run); i++) cycle();
    endtask

    task automatic test_reset();
        reset = 1; cfg_enable = 0; cfg_period = '0; cfg_evt_sel = '0; smp.smp_ready = 0;
        cycle_count = $urandom(); instret_count = $urandom();
        for (int i = 0; i < NE; i++) evt[i] = $urandom();
        model_reset();
        @(negedge clk);
        vectors++; if (smp.smp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", smp.smp_valid); end
        vectors++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        vectors++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
        vectors++; if (smp.smp_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", smp.smp_data); end
        reset = 0;
    endtask

    task automatic test_basic();
        int first = -1;
        mode = 0; cfg_period = 16'd9; cfg_evt_sel = 5'd3; smp.smp_ready = 1; cfg_enable = 1;
        for (int c = 0; c < 45; c++) begin
            if (smp.smp_valid) begin
                vectors++;
                if (smp.smp_data !== {32'd2, 32'd5, 32'd10}) begin
                    errors++; $display("FAIL basic_rec got %h exp {2,5,10}", smp.smp_data);
                end
            end
            cycle();
            if (first < 0 && smp.smp_valid) first = c;
            vectors++; if (fifo_level !== LW'(m_q.size())) begin errors++; $display("FAIL basic_level got %0d exp %0d", fifo_level, m_q.size()); end
        end
        vectors++; if (first !== 10) begin errors++; $display("FAIL basic_latency got %0d exp 10", first); end
        drain();
    endtask

    task automatic test_wrap();
        bit seen = 0;
        mode = 0; cycle_count = 32'hFFFF_FFFA; cfg_period = 16'd15; cfg_evt_sel = 5'd3; cfg_enable = 1;
        for (int c = 0; c < 25; c++) begin
            if (smp.smp_valid && !seen) begin
                seen = 1;
                vectors++;
                if (smp.smp_data[31:0] !== 32'd16) begin errors++; $display("FAIL wrap_cyc got %0d exp 16", smp.smp_data[31:0]); end
            end
            cycle();
        end
        vectors++; if (!seen) begin errors++; $display("FAIL wrap_timeout got none exp record"); end
        drain();
    endtask

    task automatic test_backpressure();
        int d0, pops = 0;
        mode = 1; cfg_period = 16'd3; cfg_evt_sel = 4'($urandom_range(0, 15)); smp.smp_ready = 0; cfg_enable = 1;
        d0 = int'(drop_count);
        for (int c = 0; c < 60; c++) cycle();
        vectors++; if (fifo_level !== LW'(8)) begin errors++; $display("FAIL bp_level got %0d exp 8", fifo_level); end
        vectors++; if (int'(drop_count) - d0 !== 6) begin errors++; $display("FAIL bp_drops got %0d exp 6", int'(drop_count) - d0); end
        smp.smp_ready = 1;
        for (int c = 0; c < 40 && pops < 10; c++) begin
            if (smp.smp_valid) begin
                pops++;
                vectors++;
                if (pops == 9) begin
                    if (smp.smp_data[31:0] !== 32'd28) begin errors++; $display("FAIL bp_merged got %0d exp 28", smp.smp_data[31:0]); end
                end else if (smp.smp_data[31:0] !== 32'd4) begin
                    errors++; $display("FAIL bp_rec%0d got %0d exp 4", pops, smp.smp_data[31:0]);
                end
                vectors++;
                if (smp.smp_data !== m_q[0]) begin errors++; $display("FAIL bp_model got %h exp %h", smp.smp_data, m_q[0]); end
            end
            cycle();
        end
        vectors++; if (pops < 10) begin errors++; $display("FAIL bp_timeout got %0d pops exp 10", pops); end
        drain();
    endtask

    task automatic test_full_pop();
        int d0;
        bit done = 0;
        mode = 1; cfg_period = 16'd2; cfg_evt_sel = 5'd5; smp.smp_ready = 0; cfg_enable = 1;
        for (int c = 0; c < 40; c++) cycle();
        vectors++; if (fifo_level !== LW'(8)) begin errors++; $display("FAIL fp_full got %0d exp 8", fifo_level); end
        for (int c = 0; c < 8 && !done; c++) begin
            if ((m_k % (m_period + 1)) == m_period) begin
                d0 = int'(drop_count);
                smp.smp_ready = 1;
                cycle();
                smp.smp_ready = 0;
                done = 1;
                vectors++; if (fifo_level !== LW'(8)) begin errors++; $display("FAIL fp_level got %0d exp 8", fifo_level); end
                vectors++; if (int'(drop_count) !== d0) begin errors++; $display("FAIL fp_drop got %0d exp %0d", drop_count, d0); end
                vectors++; if (smp.smp_data !== m_q[0]) begin errors++; $display("FAIL fp_head got %h exp %h", smp.smp_data, m_q[0]); end
            end else begin
                cycle();
            end
        end
        vectors++; if (!done) begin errors++; $display("FAIL fp_timeout got no tick exp tick"); end
        drain();
    endtask

    task automatic test_config_latch();
        mode = 1; cfg_period = 16'd4; cfg_evt_sel = 5'd2; cfg_enable = 1;
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 40; c++) begin
                smp.smp_ready = 1'($urandom_range(0, 1));
                if (c == 10) begin cfg_evt_sel = 5'($urandom_range(0, 15)); cfg_period = 16'($urandom_range(0, 6)); end
                cycle();
                vectors++; if (smp.smp_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL cfg_valid got %b exp %b", smp.smp_valid, m_q.size() != 0); end
                if (m_q.size() != 0) begin
                    vectors++; if (smp.smp_data !== m_q[0]) begin errors++; $display("FAIL cfg_data got %h exp %h", smp.smp_data, m_q[0]); end
                end
                vectors++; if (running !== m_run) begin errors++; $display("FAIL cfg_running got %b exp %b", running, m_run); end
            end
            cfg_enable = 0;
            for (int c = 0; c < 3; c++) cycle();
            cfg_evt_sel = 5'd7; cfg_period = 16'd3; cfg_enable = 1;
        end
        drain();
    endtask

    task automatic test_oob();
        int seen = 0;
        mode = 1; cfg_period = 16'd2; cfg_evt_sel = 5'd31; smp.smp_ready = 1; cfg_enable = 1;
        for (int c = 0; c < 15; c++) begin
            if (smp.smp_valid) begin
                seen++;
                vectors++;
                if (smp.smp_data[95:64] !== 32'd0) begin errors++; $display("FAIL oob_evt got %h exp 0", smp.smp_data[95:64]); end
            end
            cycle();
        end
        vectors++; if (seen == 0) begin errors++; $display("FAIL oob_timeout got 0 records exp >0"); end
        drain();
    endtask

    task automatic test_random();
        mode = 1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) cfg_enable = ~cfg_enable;
            cfg_period  = 16'($urandom_range(0, 5));
            cfg_evt_sel = 5'($urandom_range(0, 31));
            smp.smp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            vectors++; if (smp.smp_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid got %b exp %b", smp.smp_valid, m_q.size() != 0); end
            vectors++; if (fifo_level !== LW'(m_q.size())) begin errors++; $display("FAIL rnd_level got %0d exp %0d", fifo_level, m_q.size()); end
            if (m_q.size() != 0) begin
                vectors++; if (smp.smp_data !== m_q[0]) begin errors++; $display("FAIL rnd_data got %h exp %h", smp.smp_data, m_q[0]); end
            end
            vectors++; if (drop_count !== DW'(m_drops)) begin errors++; $display("FAIL rnd_drop got %0d exp %0d", drop_count, m_drops); end
            vectors++; if (running !== m_run) begin errors++; $display("FAIL rnd_running got %b exp %b", running, m_run); end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        mode = 1; cfg_period = 16'd0; cfg_evt_sel = 5'd1; smp.smp_ready = 0; cfg_enable = 1;
        for (int c = 0; c < 12 && m_q.size() < 5; c++) cycle();
        vectors++; if (fifo_level !== LW'(5)) begin errors++; $display("FAIL rst_pre_level got %0d exp 5", fifo_level); end
        #2 reset = 1;
        #1;
        vectors++; if (smp.smp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", smp.smp_valid); end
        vectors++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        vectors++; if (drop_count !== '0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
        vectors++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %b exp 0", running); end
        model_reset();
        cfg_enable = 0;
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        n = 0; mode = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_full_pop();
        test_config_latch();
        test_oob();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
